// File: rtl/fp_div_sqrt_issue_arbiter_pkg.sv
// rtl/fp_div_sqrt_issue_arbiter_pkg.sv - shared types and defaults for the FP div/sqrt issue arbiter
package fp_div_sqrt_issue_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC    = 2'd1,
    WAIT_WB = 2'd2
  } fp_div_sqrt_state_e;

  localparam int FP_ISSUE_WIDTH          = 2;
  localparam int FP_DIVSQRT_DIV_LATENCY  = 18;
  localparam int FP_DIVSQRT_SQRT_LATENCY = 25;
  localparam int FP_TAG_WIDTH            = 7;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fp_div_sqrt_issue_arbiter_rr_picker.sv
// rtl/fp_div_sqrt_issue_arbiter_rr_picker.sv - combinational round-robin picker starting at ptr
module fp_rr_picker #(
  parameter int ISSUE_WIDTH = 2,
  parameter int PTR_W       = 1
) (
  input  logic [ISSUE_WIDTH-1:0] req,
  input  logic [PTR_W-1:0]       ptr,
  output logic [ISSUE_WIDTH-1:0] grant,
  output logic [PTR_W-1:0]       idx
);

  // Walk offsets from farthest to nearest so the lane closest to ptr is written last.
  always_comb begin : pick
    int cand;
    grant = '0;
    idx   = '0;
    cand  = 0;
    for (int off = ISSUE_WIDTH - 1; off >= 0; off--) begin
      cand = int'(ptr) + off;
      if (cand >= ISSUE_WIDTH) cand = cand - ISSUE_WIDTH;
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        idx         = cand[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/fp_div_sqrt_issue_arbiter.sv
// rtl/fp_div_sqrt_issue_arbiter.sv - shares one unpipelined FP div/sqrt unit among the FP issue lanes
module fp_div_sqrt_issue_arbiter
  import fp_div_sqrt_issue_arbiter_pkg::*;
#(
  parameter int ISSUE_WIDTH  = FP_ISSUE_WIDTH,
  parameter int DIV_LATENCY  = FP_DIVSQRT_DIV_LATENCY,
  parameter int SQRT_LATENCY = FP_DIVSQRT_SQRT_LATENCY,
  parameter int TAG_WIDTH    = FP_TAG_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ISSUE_WIDTH-1:0]         req_valid,
  input  logic [ISSUE_WIDTH-1:0]         req_is_sqrt,
  input  logic [ISSUE_WIDTH*TAG_WIDTH-1:0] req_tag,
  output logic [ISSUE_WIDTH-1:0]         grant,
  output logic [ISSUE_WIDTH-1:0]         stall,
  output logic                           unit_start,
  output logic                           unit_is_sqrt,
  output logic [TAG_WIDTH-1:0]           unit_tag,
  input  logic                           flush,
  input  logic                           wb_ready,
  output logic                           result_valid,
  output logic [TAG_WIDTH-1:0]           result_tag,
  output logic                           busy
);

  localparam int PTR_W = (ISSUE_WIDTH > 1) ? $clog2(ISSUE_WIDTH) : 1;
  localparam int CNT_W = $clog2(max_int(DIV_LATENCY, SQRT_LATENCY));
  localparam logic [CNT_W-1:0] DIV_CNT_INIT  = CNT_W'(DIV_LATENCY - 2);
  localparam logic [CNT_W-1:0] SQRT_CNT_INIT = CNT_W'(SQRT_LATENCY - 2);

  if (DIV_LATENCY < 2 || SQRT_LATENCY < 2) begin : g_bad_latency
    $error("fp_div_sqrt_issue_arbiter: DIV_LATENCY and SQRT_LATENCY must be >= 2");
  end

  fp_div_sqrt_state_e   state, state_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic [TAG_WIDTH-1:0] cur_tag, cur_tag_d;
  logic                 cur_sqrt, cur_sqrt_d;
  logic [PTR_W-1:0]     rr_ptr, rr_ptr_d;

  logic [ISSUE_WIDTH-1:0] pick_grant;
  logic [PTR_W-1:0]       pick_idx;
  logic [TAG_WIDTH-1:0]   sel_tag;
  logic                   sel_sqrt;
  logic                   can_grant;

  fp_rr_picker #(
    .ISSUE_WIDTH (ISSUE_WIDTH),
    .PTR_W       (PTR_W)
  ) u_picker (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  assign sel_tag  = req_tag[int'(pick_idx)*TAG_WIDTH +: TAG_WIDTH];
  assign sel_sqrt = req_is_sqrt[pick_idx];

  // Outputs are gated with rst so they read zero for the whole reset pulse, not just after the edge.
  assign can_grant    = ~rst & (state == IDLE) & ~flush;
  assign grant        = can_grant ? pick_grant : '0;
  assign unit_start   = |grant;
  assign unit_is_sqrt = unit_start & sel_sqrt;
  assign unit_tag     = unit_start ? sel_tag : '0;
  assign stall        = rst ? '0 : (req_valid & ~grant);
  assign result_valid = ~rst & (state == WAIT_WB) & ~flush;
  assign result_tag   = result_valid ? cur_tag : '0;
  assign busy         = ~rst & (state != IDLE);

  always_comb begin : fsm_next
    int nxt;
    state_d    = state;
    cnt_d      = cnt;
    cur_tag_d  = cur_tag;
    cur_sqrt_d = cur_sqrt;
    rr_ptr_d   = rr_ptr;
    nxt        = int'(pick_idx) + 1;
    if (nxt >= ISSUE_WIDTH) nxt = 0;

    case (state)
      IDLE: begin
        if (unit_start) begin
          state_d    = EXEC;
          cnt_d      = sel_sqrt ? SQRT_CNT_INIT : DIV_CNT_INIT;
          cur_tag_d  = sel_tag;
          cur_sqrt_d = sel_sqrt;
          rr_ptr_d   = nxt[PTR_W-1:0];
        end
      end
      EXEC: begin
        if (cnt == '0) state_d = WAIT_WB;
        else           cnt_d   = cnt - 1'b1;
      end
      WAIT_WB: begin
        if (wb_ready && result_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      cur_tag  <= '0;
      cur_sqrt <= 1'b0;
      rr_ptr   <= '0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      cur_tag  <= cur_tag_d;
      cur_sqrt <= cur_sqrt_d;
      rr_ptr   <= rr_ptr_d;
    end
  end

  a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
  a_no_grant_busy: assert property (@(posedge clk) disable iff (rst) !(busy && |grant));
  a_result_state: assert property (@(posedge clk) disable iff (rst) result_valid |-> state == WAIT_WB);
  a_cnt_range: assert property (@(posedge clk) disable iff (rst)
    state == EXEC |-> cnt <= (cur_sqrt ? SQRT_CNT_INIT : DIV_CNT_INIT));

endmodule
